// File: rtl/pipelined_fp_to_int.sv
// -----------------------------------------------------------------------------
// pipelined_fp_to_int
//   Three-stage pipelined IEEE-754 binary32 -> signed int32 converter.
//   Stage 1 unpacks the operand and classifies it (zero/denormal, inf, NaN).
//   Stage 2 aligns the significand into a 32-bit magnitude plus guard/sticky.
//   Stage 3 rounds, applies the sign, saturates and encodes the status.
//
// Optional feature macro:
//   FP_TO_INT_ROUND_NEAREST_EN  defined   -> round to nearest, ties to even
//                               undefined -> truncate toward zero
//
// Ports:
//   clk           in   1   clock, all state on rising edge
//   rst           in   1   asynchronous reset, active low
//   a_i           in   32  binary32 operand
//   vld_i         in   1   a_i valid this cycle
//   answer_o      out  32  two's-complement int32 result
//   vld_o         out  1   answer_o / num_status_o valid this cycle
//   num_status_o  out  2   00 exact, 01 inexact, 10 saturated, 11 NaN
// -----------------------------------------------------------------------------

package float_types_pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_point_num;
endpackage

module pipelined_fp_to_int
  import float_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_i,
  input  logic        vld_i,
  output logic [31:0] answer_o,
  output logic        vld_o,
  output logic [1:0]  num_status_o
);

  localparam logic [1:0]  ST_EXACT   = 2'b00;
  localparam logic [1:0]  ST_INEXACT = 2'b01;
  localparam logic [1:0]  ST_OVF     = 2'b10;
  localparam logic [1:0]  ST_NAN     = 2'b11;
  localparam logic [31:0] INT_MAX    = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  // ---------------------------------------------------------------------------
  // Stage 1: unpack and classify
  // ---------------------------------------------------------------------------
  float_point_num w_a_num;
  float_point_num r_s1_num;
  logic           r_s1_vld;
  logic           r_s1_zero;
  logic           r_s1_inf;
  logic           r_s1_nan;

  assign w_a_num = a_i;

  // Stage 1 register: data only loads on a valid slot to avoid needless toggling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_num  <= '0;
      r_s1_zero <= 1'b0;
      r_s1_inf  <= 1'b0;
      r_s1_nan  <= 1'b0;
    end else begin
      r_s1_vld <= vld_i;
      if (vld_i) begin
        r_s1_num  <= w_a_num;
        r_s1_zero <= (w_a_num.exp == 8'd0);
        r_s1_inf  <= (w_a_num.exp == 8'hFF) && (w_a_num.mant == 23'd0);
        r_s1_nan  <= (w_a_num.exp == 8'hFF) && (w_a_num.mant != 23'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: align
  // ---------------------------------------------------------------------------
  logic [23:0]       w_sig;
  logic signed [8:0] w_e;
  logic [7:0]        w_rsh;
  logic [7:0]        w_lsh;
  logic [47:0]       w_ext;
  logic [31:0]       w_mag;
  logic              w_guard;
  logic              w_sticky;
  logic              w_ovf;

  assign w_sig = r_s1_zero ? 24'd0 : {1'b1, r_s1_num.mant};
  assign w_e   = $signed({1'b0, r_s1_num.exp}) - 9'sd127;
  // Only meaningful inside the ranges where each is used below.
  assign w_rsh = 8'd150 - r_s1_num.exp;
  assign w_lsh = r_s1_num.exp - 8'd150;

  // Alignment: integer magnitude plus the first dropped bit (guard) and the
  // OR of all lower dropped bits (sticky).
  always_comb begin
    w_ext    = 48'd0;
    w_mag    = 32'd0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    w_ovf    = 1'b0;
    if (r_s1_nan) begin
      w_ovf = 1'b0;
    end else if (r_s1_inf) begin
      w_ovf = 1'b1;
    end else if (w_e >= 9'sd31) begin
      // -2^31 is the single e==31 value that fits in int32.
      if ((w_e == 9'sd31) && r_s1_num.sign && (r_s1_num.mant == 23'd0)) begin
        w_mag = INT_MIN;
      end else begin
        w_ovf = 1'b1;
      end
    end else if (w_e >= 9'sd24) begin
      w_mag = {8'd0, w_sig} << w_lsh;
    end else if (w_e >= -9'sd1) begin
      // {sig, 24 zero bits} keeps every shifted-out bit for guard/sticky;
      // e == -1 shifts by 24 so the top significand bit lands on guard.
      w_ext    = {w_sig, 24'd0} >> w_rsh;
      w_mag    = {8'd0, w_ext[47:24]};
      w_guard  = w_ext[23];
      w_sticky = |w_ext[22:0];
    end else begin
      // |value| < 0.5: guard is clear; sticky marks any nonzero input,
      // including denormals whose implicit significand is zero.
      w_sticky = r_s1_zero ? (r_s1_num.mant != 23'd0) : 1'b1;
    end
  end

  logic        r_s2_vld;
  logic        r_s2_sign;
  logic [31:0] r_s2_mag;
  logic        r_s2_guard;
  logic        r_s2_sticky;
  logic        r_s2_ovf;
  logic        r_s2_nan;

  // Stage 2 register: holds aligned magnitude and exception flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_vld    <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_mag    <= 32'd0;
      r_s2_guard  <= 1'b0;
      r_s2_sticky <= 1'b0;
      r_s2_ovf    <= 1'b0;
      r_s2_nan    <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_sign   <= r_s1_num.sign;
        r_s2_mag    <= w_mag;
        r_s2_guard  <= w_guard;
        r_s2_sticky <= w_sticky;
        r_s2_ovf    <= w_ovf;
        r_s2_nan    <= r_s1_nan;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: round, sign, saturate, status
  // ---------------------------------------------------------------------------
  logic [32:0] w_rmag;

`ifdef FP_TO_INT_ROUND_NEAREST_EN
  logic w_inc;
  // Ties-to-even: bump on guard when either sticky or the lsb is set.
  assign w_inc  = r_s2_guard & (r_s2_sticky | r_s2_mag[0]);
  assign w_rmag = {1'b0, r_s2_mag} + {32'd0, w_inc};
`else
  assign w_rmag = {1'b0, r_s2_mag};
`endif

  logic [31:0] w_ans;
  logic [1:0]  w_status;
  logic        w_range_ovf;

  // Negative results may reach 2^31 in magnitude, positive ones only 2^31-1.
  assign w_range_ovf = r_s2_sign ? (w_rmag > 33'h0_8000_0000)
                                 : (w_rmag > 33'h0_7FFF_FFFF);

  // Result select with priority NaN > overflow > inexact > exact
  always_comb begin
    w_ans    = 32'd0;
    w_status = ST_EXACT;
    if (r_s2_nan) begin
      w_ans    = INT_MAX;
      w_status = ST_NAN;
    end else if (r_s2_ovf || w_range_ovf) begin
      w_ans    = r_s2_sign ? INT_MIN : INT_MAX;
      w_status = ST_OVF;
    end else begin
      w_ans    = r_s2_sign ? (32'd0 - w_rmag[31:0]) : w_rmag[31:0];
      w_status = (r_s2_guard || r_s2_sticky) ? ST_INEXACT : ST_EXACT;
    end
  end

  // Output register: results hold their last value while no slot is valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_o        <= 1'b0;
      answer_o     <= 32'd0;
      num_status_o <= ST_EXACT;
    end else begin
      vld_o <= r_s2_vld;
      if (r_s2_vld) begin
        answer_o     <= w_ans;
        num_status_o <= w_status;
      end
    end
  end

endmodule

// File: doc/pipelined_fp_to_int.md
PIPELINED_FP_TO_INT -- requirements
Module: pipelined_fp_to_int

Interface
REQ-001 The block SHALL use float_types_pkg::float_point_num (sign, exp[7:0], mant[22:0]) for internal stage registers.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 a_i  input  32  IEEE-754 binary32 operand.
REQ-005 vld_i  input  1  a_i valid this cycle; one conversion per cycle, no backpressure.
REQ-006 answer_o  output  32  signed two's-complement int32 result.
REQ-007 vld_o  output  1  answer_o/num_status_o valid this cycle.
REQ-008 num_status_o  output  2  00 exact, 01 inexact, 10 overflow/saturated, 11 NaN.

Function
REQ-009 The block SHALL be a 3-stage pipeline with latency exactly 3 cycles, vld_i at edge N giving vld_o high after edge N+3.
REQ-010 Stage 1 (unpack) SHALL register sign, exp and mant, plus class flags: zero/denormal (exp==0), inf (exp==255, mant==0), NaN (exp==255, mant!=0).
REQ-011 Stage 2 (align) SHALL form the 24-bit significand {1,mant} (0 for exp==0), compute e = exp-127, and shift into a 32-bit integer magnitude plus guard bit and sticky bit.
REQ-012 If e<0, the magnitude SHALL be 0 with guard/sticky taken from the shifted-out bits; if 0<=e<=23, shift right by 23-e; if 24<=e<=30, shift left by e-23.
REQ-013 Stage 3 (round/sign) SHALL apply rounding (REQ-024), negate if sign=1, saturate and encode status.
REQ-014 Overflow: e>=31, or rounded magnitude >2^31-1 (sign 0) or >2^31 (sign 1), SHALL give 32'h7FFF_FFFF (sign 0) or 32'h8000_0000 (sign 1) with status 10.
REQ-015 Exactly -2^31 (a_i=32'hCF00_0000) SHALL give 32'h8000_0000 with status 00.
REQ-016 ±inf SHALL saturate per REQ-014 with status 10; NaN (any sign) SHALL give 32'h7FFF_FFFF with status 11.
REQ-017 Denormals and ±0 SHALL give 0; status 01 for a nonzero denormal, 00 for ±0.
REQ-018 Status 01 SHALL be reported whenever guard|sticky=1 and no overflow or NaN occurred.
REQ-019 Status priority SHALL be NaN > overflow > inexact > exact.
REQ-020 A valid bit SHALL travel with each stage; data registers of invalid slots SHALL hold their previous value to save toggling.
REQ-021 Outputs SHALL hold their last values while vld_o=0; answer_o and num_status_o are meaningful only when vld_o=1.
REQ-022 Back-to-back vld_i SHALL produce back-to-back vld_o with no bubbles; gaps in vld_i SHALL be reproduced in vld_o exactly.

Reset
REQ-023 While rst=0, all stage valid bits, vld_o, answer_o (32'h0) and num_status_o (2'b00) SHALL clear immediately; in-flight operands SHALL be discarded, and the first vld_o after release SHALL come from the first vld_i sampled after release.

Configuration
REQ-024 With macro FP_TO_INT_ROUND_NEAREST_EN defined, stage 3 SHALL round to nearest, ties to even (increment when guard & (sticky | lsb)); without it, the block SHALL truncate toward zero with no increment logic; status 01 reporting SHALL be identical in both builds.

Verification
REQ-025 a_i=32'hC2F6_0000 (-123.0), vld_i pulse at cycle 0 -> vld_o=1 at cycle 3, answer_o=32'hFFFF_FF85, status 00.
REQ-026 a_i=32'h3FC0_0000 (1.5) then 32'h4020_0000 (2.5) back-to-back -> with _EN: 2 then 2; without: 1 then 2; status 01 both; vld_o high on 2 consecutive cycles.
REQ-027 a_i=32'h4F00_0000 (2^31) -> 32'h7FFF_FFFF, status 10; a_i=32'hCF00_0000 -> 32'h8000_0000, status 00; a_i=32'hFF80_0000 (-inf) -> 32'h8000_0000, status 10.
REQ-028 a_i=32'h7FC0_0000 (NaN) -> 32'h7FFF_FFFF, status 11; a_i=32'h0000_0001 (denormal) -> 0, status 01; a_i=32'h8000_0000 -> 0, status 00.
REQ-029 Stream 10 valid operands, assert rst=0 for 1 cycle at cycle 5 -> outputs clear asynchronously, no vld_o for pre-reset operands; post-reset operands emerge 3 cycles after their vld_i.
